// File: rtl/rnd_sig_responder.sv
// ---------------------------------------------------------------------------
// rnd_sig_responder
//
// Purpose:
//   Consumer end of the random-signal generator. A 2-bit quadrant code is
//   accepted with a one-cycle strobe. The matching one of four LEDs is lit,
//   and the block then waits for the player to press the matching
//   push-button. A correct, wrong or missing (timed-out) response is scored
//   into saturating hit/miss counters.
//
// Ports:
//   clk        in   1        system clock
//   reset      in   1        asynchronous, active-high reset
//   sig_valid  in   1        one-cycle strobe, sig valid this cycle
//   sig        in   2        quadrant code 0..3 (target button / LED)
//   btn        in   4        raw push-buttons, active-high, async to clk
//   led        out  4        one-hot target indicator, zero when not armed
//   busy       out  1        high while a round is in progress
//   hit        out  1        one-cycle pulse on a correct response
//   miss       out  1        one-cycle pulse on a wrong press or timeout
//   hits       out  SCORE_W  saturating hit count
//   misses     out  SCORE_W  saturating miss count
// ---------------------------------------------------------------------------
module rnd_sig_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig_valid,
  input  logic [1:0]         sig,
  input  logic [3:0]         btn,
  output logic [3:0]         led,
  output logic               busy,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses
);

  // Timer only ever has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]      TIMER_ONE  = TW'(1'b1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1'b1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  // Saturating increment shared by both score counters.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (v == SCORE_MAX) begin
      r = v;
    end else begin
      r = v + SCORE_ONE;
    end
    return r;
  endfunction

  // Button synchronizer and edge-detect flops.
  logic [3:0]         btn_s1_q;
  logic [3:0]         btn_s2_q;
  logic [3:0]         btn_dly_q;
  logic [3:0]         press;

  // FSM and datapath state.
  logic [0:0]         state_q,  state_d;
  logic [1:0]         target_q, target_d;
  logic [TW-1:0]      timer_q,  timer_d;
  logic [3:0]         led_q,    led_d;
  logic               busy_q,   busy_d;
  logic               hit_q,    hit_d;
  logic               miss_q,   miss_d;
  logic [SCORE_W-1:0] hits_q,   hits_d;
  logic [SCORE_W-1:0] misses_q, misses_d;
  logic [3:0]         target_onehot;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q  <= 4'b0000;
      btn_s2_q  <= 4'b0000;
      btn_dly_q <= 4'b0000;
    end else begin
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      btn_dly_q <= btn_s2_q;
    end
  end

  // A held button yields a single press on its rising edge only.
  assign press = btn_s2_q & ~btn_dly_q;

  assign target_onehot = 4'b0001 << target_q;

  // Round control: arm on strobe, then score a press or a timeout.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    timer_d  = timer_q;
    led_d    = led_q;
    busy_d   = busy_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    hits_d   = hits_q;
    misses_d = misses_q;
    case (state_q)
      S_IDLE: begin
        // Presses in IDLE are deliberately not looked at.
        if (sig_valid) begin
          target_d = sig;
          led_d    = 4'b0001 << sig;
          timer_d  = {TW{1'b0}};
          busy_d   = 1'b1;
          state_d  = S_ARMED;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ARMED: begin
        // A press outranks the timeout when both fall on the same cycle;
        // sig_valid is ignored for the whole round.
        if (press != 4'b0000) begin
          if (press == target_onehot) begin
            hit_d  = 1'b1;
            hits_d = sat_inc(hits_q);
          end else begin
            miss_d   = 1'b1;
            misses_d = sat_inc(misses_q);
          end
          led_d   = 4'b0000;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          miss_d   = 1'b1;
          misses_d = sat_inc(misses_q);
          led_d    = 4'b0000;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          timer_d  = timer_q + TIMER_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, outputs and counters; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= 2'b00;
      timer_q  <= {TW{1'b0}};
      led_q    <= 4'b0000;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      hits_q   <= {SCORE_W{1'b0}};
      misses_q <= {SCORE_W{1'b0}};
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign led    = led_q;
  assign busy   = busy_q;
  assign hit    = hit_q;
  assign miss   = miss_q;
  assign hits   = hits_q;
  assign misses = misses_q;

endmodule

// File: tb/tb_rnd_sig_responder.sv
// ---------------------------------------------------------------------------
// tb_rnd_sig_responder
//
// Directed bench for rnd_sig_responder with TIMEOUT_CYCLES=20, SCORE_W=2.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at that same point, so every sample reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_rnd_sig_responder;

  localparam int unsigned TO = 20;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          sig_valid;
  logic [1:0]    sig;
  logic [3:0]    btn;
  logic [3:0]    led;
  logic          busy;
  logic          hit;
  logic          miss;
  logic [SW-1:0] hits;
  logic [SW-1:0] misses;

  int vectors    = 0;
  int miscompares = 0;

  rnd_sig_responder #(.TIMEOUT_CYCLES(TO), .SCORE_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_valid (sig_valid),
    .sig       (sig),
    .btn       (btn),
    .led       (led),
    .busy      (busy),
    .hit       (hit),
    .miss      (miss),
    .hits      (hits),
    .misses    (misses)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe a code for one edge and check the LED lights right after it.
  task automatic strobe(input logic [1:0] code);
    sig_valid = 1'b1;
    sig       = code;
    tick();
    sig_valid = 1'b0;
    chk("led_on", {28'd0, led}, {28'd0, 4'b0001 << code});
    chk("busy_on", {31'd0, busy}, 32'd1);
  endtask

  // Raise mask bits, expect the pulse three edges later, then release.
  task automatic do_press(input logic [3:0] mask, input bit exp_hit);
    btn = btn | mask;
    tick();
    tick();
    chk("pre_pulse", {30'd0, hit, miss}, 32'd0);
    tick();
    chk("hit_pulse",  {31'd0, hit},  {31'd0, exp_hit});
    chk("miss_pulse", {31'd0, miss}, {31'd0, ~exp_hit});
    chk("led_off",  {28'd0, led}, 32'd0);
    chk("busy_off", {31'd0, busy}, 32'd0);
    btn = btn & ~mask;
    tick();
    chk("pulse_one_cycle", {30'd0, hit, miss}, 32'd0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    sig_valid = 1'b0;
    sig       = 2'd0;
    btn       = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_led",    {28'd0, led},    32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_pulses", {30'd0, hit, miss}, 32'd0);
    chk("rst_hits",   {30'd0, hits},   32'd0);
    chk("rst_misses", {30'd0, misses}, 32'd0);

    // Correct press on target 2, raised 5 cycles after the strobe.
    strobe(2'd2);
    chk("led_0100", {28'd0, led}, 32'h4);
    for (int i = 0; i < 4; i++) tick();
    do_press(4'b0100, 1'b1);
    chk("hits_1",   {30'd0, hits},   32'd1);
    chk("misses_0", {30'd0, misses}, 32'd0);

    // Wrong button.
    strobe(2'd1);
    tick();
    do_press(4'b1000, 1'b0);
    chk("misses_1", {30'd0, misses}, 32'd1);
    chk("hits_kept", {30'd0, hits},  32'd1);

    // Target plus a second button in the same cycle.
    strobe(2'd1);
    tick();
    do_press(4'b0011, 1'b0);
    chk("misses_2", {30'd0, misses}, 32'd2);

    // Timeout: miss exactly TO edges after the LED lights.
    strobe(2'd0);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("no_early_timeout", {31'd0, miss}, 32'd0);
    end
    tick();
    chk("timeout_miss", {31'd0, miss}, 32'd1);
    chk("timeout_hit0", {31'd0, hit},  32'd0);
    chk("misses_3",     {30'd0, misses}, 32'd3);
    chk("timeout_led",  {28'd0, led},  32'd0);
    tick();

    // Press landing on the timeout cycle wins as a hit.
    strobe(2'd0);
    for (int i = 0; i < TO - 3; i++) tick();
    btn = 4'b0001;
    tick();
    tick();
    chk("late_no_pulse", {30'd0, hit, miss}, 32'd0);
    tick();
    chk("late_hit",  {31'd0, hit},  32'd1);
    chk("late_miss", {31'd0, miss}, 32'd0);
    chk("hits_2",    {30'd0, hits}, 32'd2);
    btn = 4'b0000;
    for (int i = 0; i < 4; i++) tick();

    // Strobe while ARMED is ignored; timer keeps running from the first.
    strobe(2'd0);
    for (int i = 0; i < 4; i++) tick();
    sig_valid = 1'b1;
    sig       = 2'd3;
    tick();
    sig_valid = 1'b0;
    chk("retarget_ignored", {28'd0, led}, 32'h1);
    for (int i = 6; i < TO; i++) tick();
    chk("retarget_no_miss", {31'd0, miss}, 32'd0);
    // Strobe on the edge that returns to IDLE is also ignored.
    sig_valid = 1'b1;
    sig       = 2'd2;
    tick();
    sig_valid = 1'b0;
    chk("retarget_timeout", {31'd0, miss}, 32'd1);
    chk("misses_sat",       {30'd0, misses}, 32'd3);
    chk("return_strobe_led", {28'd0, led}, 32'd0);
    tick();
    chk("return_strobe_busy", {31'd0, busy}, 32'd0);

    // Presses in IDLE and a button held into a new round.
    btn = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_press_hits",   {30'd0, hits},   32'd2);
    chk("idle_press_misses", {30'd0, misses}, 32'd3);
    strobe(2'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("held_no_pulse", {30'd0, hit, miss}, 32'd0);
    chk("held_busy",     {31'd0, busy}, 32'd1);
    btn = 4'b0000;
    tick();
    tick();
    tick();
    do_press(4'b0001, 1'b1);
    chk("hits_3", {30'd0, hits}, 32'd3);

    // Reset, then four hits saturate the 2-bit counter at 3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_hits", {30'd0, hits}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      strobe(r[1:0]);
      tick();
      do_press(4'b0001 << r[1:0], 1'b1);
      chk("sat_hits", {30'd0, hits}, (r < 3) ? r + 1 : 3);
    end

    // Async reset in the middle of an armed round.
    strobe(2'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_led",    {28'd0, led},    32'd0);
    chk("mid_rst_busy",   {31'd0, busy},   32'd0);
    chk("mid_rst_hits",   {30'd0, hits},   32'd0);
    chk("mid_rst_misses", {30'd0, misses}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_pulse", {30'd0, hit, miss}, 32'd0);
    strobe(2'd2);
    tick();
    do_press(4'b0100, 1'b1);
    chk("post_rst_hits", {30'd0, hits}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rnd_sig_responder.md
Name: rnd_sig_responder

Overview:
- Consumer end of the random-signal generator. It accepts each 2-bit quadrant code (`sig`) with a valid strobe and lights the matching one of four LEDs.
- It then waits for the player to press the matching push-button, and scores a hit or a miss.
- Sits between the generator's `sig` output and the board buttons/LEDs. Provides saturating hit/miss counters for display logic.

Parameters:
- `TIMEOUT_CYCLES`, 50_000_000, clk cycles allowed for a response after the LED lights (0.5 s at 100 MHz); legal values ≥ 2.
- `SCORE_W`, 8, width of the hit and miss counters.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `sig_valid`  input  1  one-cycle strobe; `sig` is valid this cycle.
- `sig`  input  2  quadrant code 0..3 selecting the target button/LED.
- `btn`  input  4  raw push-buttons, active-high, asynchronous to `clk`.
- `led`  output  4  one-hot target indicator; all zero when not armed.
- `busy`  output  1  high while a round is in progress (ARMED).
- `hit`  output  1  one-cycle pulse on a correct response.
- `miss`  output  1  one-cycle pulse on a wrong press or timeout.
- `hits`  output  SCORE_W  saturating count of hits.
- `misses`  output  SCORE_W  saturating count of misses.

Behaviour:
- **Reset** (async, active-high): state IDLE.
  - `led`=0, `busy`=0, `hit`=0, `miss`=0, `hits`=0, `misses`=0.
  - Timer, latched target and all synchronizer flops cleared.
- **Button input:**
  - Each `btn` bit goes through a 2-flop synchronizer plus a third flop for edge detection.
  - `press[i]` = synced & ~delayed, i.e. a rising edge.
  - A `btn` rising before clk edge k produces `press` during the cycle after edge k+1.
  - The FSM acts on it at edge k+2, so `hit`/`miss` is high for one cycle starting at edge k+2.
  - Held buttons do not re-trigger.
- **FSM states:** IDLE, ARMED.
- **IDLE:**
  - On `sig_valid`=1: latch `sig` as target, `led` <= 1<<sig, timer <= 0, `busy` <= 1, go ARMED.
  - LED lights the cycle after the strobe.
  - Presses in IDLE are ignored (no score change).
- **ARMED**, each cycle, evaluated in priority order:
  1. Any `press` bit set:
     - If `press` == only the target bit → `hit` pulse, `hits`+1.
     - Any other nonzero pattern, including target plus another button in the same cycle → `miss` pulse, `misses`+1.
     - In both cases `led` <= 0, `busy` <= 0, go IDLE.
  2. Else if timer == `TIMEOUT_CYCLES`-1 → `miss` pulse, `misses`+1, `led` <= 0, go IDLE.
  3. Else timer+1.
- **Timing boundaries:**
  - A press in the same cycle as the timeout wins (scored as a press).
  - Timer counts from 0 the cycle after arming, so the timeout `miss` rises exactly `TIMEOUT_CYCLES` cycles after `led` lights.
- **`sig_valid` boundaries:**
  - `sig_valid` while ARMED is ignored: no re-target, timer untouched.
  - `sig_valid` in the same cycle the FSM returns to IDLE is also ignored.
  - The next strobe is accepted only when state is IDLE at that edge.
- **Counters:** saturate at 2^SCORE_W−1; the `hit`/`miss` pulse is still generated at saturation.
- `hit` and `miss` are never high in the same cycle. Each is high for exactly one cycle per round.
- **Reset mid-round:** immediate return to IDLE, LED off, counters cleared, no pulse.
- Timer width is ceil(log2(`TIMEOUT_CYCLES`)) bits; no other arithmetic wraps.

Test Plan:
- **Correct press** (`TIMEOUT_CYCLES`=20): reset, strobe `sig`=2, raise `btn`[2] 5 cycles later → `led`=4'b0100 the cycle after the strobe; `hit` pulses once 3 edges after the `btn` rise; `hits`=1, `misses`=0; `led`=0 and `busy`=0 afterwards.
- **Wrong press and double press:**
  - Strobe `sig`=1, press `btn`[3] → `miss` pulse, `misses`=1, `hits` unchanged.
  - Repeat with `btn`[1] and `btn`[0] rising in the same cycle → `miss`, `misses`=2.
- **Timeout:** strobe `sig`=0, no press → `miss` exactly 20 cycles after `led`=4'b0001; `misses`+1.
  - Repeat with `btn`[0] rising so its `press` lands on the timeout cycle → `hit`, not `miss`.
- **Ignored events:**
  - Strobe `sig`=3 while ARMED on target 0 → `led` stays 4'b0001, timer unaffected.
  - Hold `btn`[0] high across a new round on target 0 → no hit until release and re-press.
  - Presses in IDLE → counters unchanged.
- **Saturation and reset:**
  - `SCORE_W`=2, four hits → `hits`=3 with 4 `hit` pulses.
  - Assert `reset` mid-ARMED → `led`=0, `hits`=`misses`=0 asynchronously, no pulse; next strobe accepted normally.
